// File: rtl/sweep_ctrl.sv
// rtl/sweep_ctrl.sv - FCW sweep sequencer driving a DDS frequency control word
module sweep_ctrl #(
    parameter int FCW_W   = 24,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [FCW_W-1:0]   cfg_start_fcw,
    input  logic [FCW_W-1:0]   cfg_stop_fcw,
    input  logic [FCW_W-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_cont,
    output logic [FCW_W-1:0]   fcw,
    output logic               fcw_upd,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t             state;
    logic [FCW_W-1:0]   sh_start;
    logic [FCW_W-1:0]   sh_stop;
    logic [FCW_W-1:0]   sh_step;
    logic [DWELL_W-1:0] sh_dwell_m1;
    logic               sh_cont;
    logic [DWELL_W-1:0] dwell_cnt;

    logic [FCW_W:0]     sum;
    logic [FCW_W-1:0]   next_fcw;
    logic [DWELL_W-1:0] cfg_dwell_m1;

    // One extra bit on the sum so an overflowing step clamps to stop instead of wrapping.
    always_comb begin
        sum          = {1'b0, fcw} + {1'b0, sh_step};
        next_fcw     = (sum <= {1'b0, sh_stop}) ? sum[FCW_W-1:0] : sh_stop;
        cfg_dwell_m1 = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            fcw         <= '0;
            fcw_upd     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            dwell_cnt   <= '0;
            sh_start    <= '0;
            sh_stop     <= '0;
            sh_step     <= '0;
            sh_dwell_m1 <= '0;
            sh_cont     <= 1'b0;
        end else begin
            fcw_upd <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_start    <= cfg_start_fcw;
                        sh_stop     <= cfg_stop_fcw;
                        sh_step     <= cfg_step;
                        sh_dwell_m1 <= cfg_dwell_m1;
                        sh_cont     <= cfg_cont;
                        fcw         <= cfg_start_fcw;
                        fcw_upd     <= 1'b1;
                        dwell_cnt   <= cfg_dwell_m1;
                        busy        <= 1'b1;
                        state       <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    end else if (fcw != sh_stop) begin
                        fcw       <= next_fcw;
                        fcw_upd   <= 1'b1;
                        dwell_cnt <= sh_dwell_m1;
                    end else if (!sh_cont) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done      <= 1'b1;
                        fcw       <= sh_start;
                        fcw_upd   <= 1'b1;
                        dwell_cnt <= sh_dwell_m1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb/tb_sweep_ctrl.sv - directed scoreboard bench for sweep_ctrl
module tb_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [23:0] cfg_start_fcw;
    logic [23:0] cfg_stop_fcw;
    logic [23:0] cfg_step;
    logic [15:0] cfg_dwell;
    logic        cfg_cont;
    logic [23:0] fcw;
    logic        fcw_upd;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [23:0] exp_q[$];

    sweep_ctrl #(.FCW_W(24), .DWELL_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_start_fcw(cfg_start_fcw), .cfg_stop_fcw(cfg_stop_fcw),
        .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .cfg_cont(cfg_cont),
        .fcw(fcw), .fcw_upd(fcw_upd), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [23:0] s, input logic [23:0] e, input logic [23:0] st,
                       input logic [15:0] d, input logic c);
        cfg_start_fcw = s;
        cfg_stop_fcw  = e;
        cfg_step      = st;
        cfg_dwell     = d;
        cfg_cont      = c;
    endtask

    // Pulse start so it is sampled at the next edge; returns just after that edge.
    task automatic kick();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    // Every fcw update must match the next value queued by the stimulus.
    always @(negedge clk) begin
        if (!reset && done) done_cnt++;
        if (!reset && fcw_upd) begin
            if (exp_q.size() == 0) chk("upd_extra", {31'b0, fcw_upd}, 32'd0);
            else chk("upd_fcw", {8'b0, fcw}, {8'b0, exp_q.pop_front()});
        end
    end

    initial begin
        int d0;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        cfg(24'd0, 24'd0, 24'd0, 16'd0, 1'b0);
        cyc(2);
        chk("rst_fcw", {8'b0, fcw}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_upd", {31'b0, fcw_upd}, 32'd0);
        reset = 1'b0;
        cyc(1);

        // Single sweep
        cfg(24'd100, 24'd130, 24'd10, 16'd4, 1'b0);
        exp_q.push_back(24'd100); exp_q.push_back(24'd110);
        exp_q.push_back(24'd120); exp_q.push_back(24'd130);
        d0 = done_cnt;
        kick();
        chk("s1_fcw_t1", {8'b0, fcw}, 32'd100);
        chk("s1_busy_t1", {31'b0, busy}, 32'd1);
        cyc(4);
        chk("s1_fcw_t5", {8'b0, fcw}, 32'd110);
        cyc(12);
        chk("s1_done_t17", {31'b0, done}, 32'd1);
        chk("s1_busy_t17", {31'b0, busy}, 32'd0);
        chk("s1_fcw_t17", {8'b0, fcw}, 32'd130);
        cyc(3);
        chk("s1_fcw_hold", {8'b0, fcw}, 32'd130);
        chk("s1_done_cnt", done_cnt - d0, 32'd1);
        chk("s1_q_empty", exp_q.size(), 32'd0);

        // Clamp and overflow
        cfg(24'hFFFFF0, 24'hFFFFFF, 24'h20, 16'd2, 1'b0);
        exp_q.push_back(24'hFFFFF0); exp_q.push_back(24'hFFFFFF);
        kick();
        cyc(2);
        chk("s2_fcw_clamp", {8'b0, fcw}, 32'hFFFFFF);
        cyc(2);
        chk("s2_done", {31'b0, done}, 32'd1);
        chk("s2_fcw_end", {8'b0, fcw}, 32'hFFFFFF);
        chk("s2_q_empty", exp_q.size(), 32'd0);
        cyc(2);

        // Continuous with abort
        cfg(24'd100, 24'd130, 24'd10, 16'd4, 1'b1);
        exp_q.push_back(24'd100); exp_q.push_back(24'd110);
        exp_q.push_back(24'd120); exp_q.push_back(24'd130);
        exp_q.push_back(24'd100);
        d0 = done_cnt;
        kick();
        cyc(16);
        chk("s3_done_t17", {31'b0, done}, 32'd1);
        chk("s3_fcw_t17", {8'b0, fcw}, 32'd100);
        chk("s3_busy_t17", {31'b0, busy}, 32'd1);
        cyc(3);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("s3_busy_abort", {31'b0, busy}, 32'd0);
        chk("s3_fcw_abort", {8'b0, fcw}, 32'd100);
        chk("s3_done_abort", {31'b0, done}, 32'd0);
        cyc(3);
        chk("s3_done_cnt", done_cnt - d0, 32'd1);
        chk("s3_q_empty", exp_q.size(), 32'd0);

        // Dwell 0 behaves as 1
        cfg(24'd5, 24'd7, 24'd1, 16'd0, 1'b0);
        exp_q.push_back(24'd5); exp_q.push_back(24'd6); exp_q.push_back(24'd7);
        kick();
        cyc(1);
        chk("s4_fcw_6", {8'b0, fcw}, 32'd6);
        chk("s4_upd_6", {31'b0, fcw_upd}, 32'd1);
        cyc(2);
        chk("s4_done", {31'b0, done}, 32'd1);
        chk("s4_busy", {31'b0, busy}, 32'd0);

        // start > stop
        cfg(24'd50, 24'd20, 24'd1, 16'd1, 1'b0);
        exp_q.push_back(24'd50); exp_q.push_back(24'd20);
        kick();
        cyc(1);
        chk("s5_fcw_20", {8'b0, fcw}, 32'd20);
        cyc(1);
        chk("s5_done", {31'b0, done}, 32'd1);
        chk("s5_q_empty", exp_q.size(), 32'd0);
        cyc(2);

        // Reset mid-sweep, then a normal sweep
        cfg(24'd100, 24'd130, 24'd10, 16'd4, 1'b0);
        exp_q.push_back(24'd100); exp_q.push_back(24'd110);
        kick();
        cyc(5);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("s6_rst_fcw", {8'b0, fcw}, 32'd0);
        chk("s6_rst_busy", {31'b0, busy}, 32'd0);
        chk("s6_rst_upd", {31'b0, fcw_upd}, 32'd0);
        chk("s6_rst_done", {31'b0, done}, 32'd0);
        cfg(24'd1, 24'd3, 24'd1, 16'd1, 1'b0);
        exp_q.push_back(24'd1); exp_q.push_back(24'd2); exp_q.push_back(24'd3);
        kick();
        cyc(3);
        chk("s6_done", {31'b0, done}, 32'd1);
        chk("s6_fcw", {8'b0, fcw}, 32'd3);
        chk("s6_q_empty", exp_q.size(), 32'd0);
        cyc(2);

        // Config isolation and start ignored in SWEEP
        cfg(24'd100, 24'd130, 24'd10, 16'd4, 1'b0);
        exp_q.push_back(24'd100); exp_q.push_back(24'd110);
        exp_q.push_back(24'd120); exp_q.push_back(24'd130);
        kick();
        cyc(1);
        cfg(24'd7, 24'd9000, 24'd3, 16'd1, 1'b1);
        start = 1'b1;
        cyc(8);
        start = 1'b0;
        cyc(6);
        chk("s7_fcw_t16", {8'b0, fcw}, 32'd130);
        cyc(1);
        chk("s7_done_t17", {31'b0, done}, 32'd1);
        chk("s7_busy_t17", {31'b0, busy}, 32'd0);
        chk("s7_q_empty", exp_q.size(), 32'd0);

        // Abort in IDLE does nothing
        abort = 1'b1;
        cyc(2);
        abort = 1'b0;
        chk("s8_idle_fcw", {8'b0, fcw}, 32'd130);
        chk("s8_idle_busy", {31'b0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 The block SHALL use these parameters (name, default, meaning): FCW_W, 24, frequency control word width; DWELL_W, 16, dwell counter width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- abort  in  1  terminate the sweep in progress.
- cfg_start_fcw  in  FCW_W  first FCW of the sweep.
- cfg_stop_fcw  in  FCW_W  last FCW of the sweep.
- cfg_step  in  FCW_W  FCW increment per step.
- cfg_dwell  in  DWELL_W  cycles each FCW is held; 0 is treated as 1.
- cfg_cont  in  1  0 = single pass; 1 = repeat passes until abort.
- fcw  out  FCW_W  registered FCW that drives the DDS fcw input.
- fcw_upd  out  1  one-cycle pulse in the cycle fcw takes a new value.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse marking the end of each pass.

Function
REQ-003 The block SHALL use two states: IDLE (busy=0) and SWEEP (busy=1); all outputs SHALL be registered.
REQ-004 In IDLE, start=1 SHALL take effect at the next edge, which SHALL:
- latch all cfg_* inputs into shadow registers;
- set fcw=cfg_start_fcw and assert fcw_upd;
- load the dwell counter with D-1, where D=max(cfg_dwell,1);
- enter SWEEP.
REQ-005 cfg_* changes after the start edge SHALL have no effect until the next start; start in SWEEP SHALL be ignored.
REQ-006 In SWEEP, each cycle with dwell counter ≠ 0 SHALL decrement it, and fcw SHALL hold; each FCW value SHALL therefore be presented for exactly D cycles.
REQ-007 In SWEEP, when the dwell counter = 0, the block SHALL take one step decision (REQ-008 to REQ-010) at that edge.
REQ-008 If fcw ≠ stop, the next FCW (computed FCW_W+1 bits wide) SHALL be:
- fcw+step when fcw+step ≤ stop;
- stop otherwise (clamp).
The block SHALL then assert fcw_upd and reload the counter with D-1.
REQ-009 If fcw = stop and cfg_cont=0, the block SHALL go to IDLE, set busy=0, pulse done for one cycle, and fcw SHALL hold stop.
REQ-010 If fcw = stop and cfg_cont=1, the block SHALL pulse done, set fcw=start, assert fcw_upd, reload the counter and remain in SWEEP.
REQ-011 Arithmetic SHALL be unsigned and SHALL never wrap; a step that would overflow FCW_W bits SHALL clamp to stop.
REQ-012 step=0 with start ≠ stop SHALL hold fcw=start indefinitely (no done) until abort.
REQ-013 start > stop SHALL produce two FCW values, start then stop, each held D cycles, then end per REQ-009/REQ-010.
REQ-014 start = stop SHALL produce one FCW value held D cycles, then end.
REQ-015 abort=1 in SWEEP SHALL force IDLE at the next edge with busy=0, fcw held at its current value, and neither done nor fcw_upd pulsed.
REQ-016 abort SHALL take priority over the step decision in the same cycle; abort in IDLE SHALL have no effect.
REQ-017 fcw_upd and done SHALL never be high for more than one consecutive cycle, except in the D=1 case (REQ-008, REQ-010) where fcw changes every cycle.

Reset
REQ-018 reset=1 SHALL, at the next edge, force IDLE with fcw=0, fcw_upd=0, busy=0, done=0, dwell counter=0 and shadow registers=0.
REQ-019 reset SHALL override start and abort in the same cycle and SHALL abandon any sweep in progress.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Single sweep: start=100, stop=130, step=10, dwell=4, start pulse at edge t -> fcw=100@t+1, 110@t+5, 120@t+9, 130@t+13; done=1 and busy=0 @t+17; fcw stays 130.
- Clamp and overflow: start=0xFFFFF0, stop=0xFFFFFF, step=0x20, dwell=2 -> fcw 0xFFFFF0 then 0xFFFFFF, then done; no wrap to small values.
- Continuous: the single-sweep config with cfg_cont=1 -> done pulse and fcw=100 @t+17, busy stays 1; abort @t+20 -> busy=0 @t+21, fcw=100, no done.
- Corner configs: dwell=0 with start=5, stop=7, step=1 -> fcw 5, 6, 7 on consecutive cycles, then done; start=50, stop=20 -> 50 then 20, then done.
- Reset mid-sweep: reset during SWEEP -> next cycle all outputs 0; a following start works normally.
- Config isolation: a start in SWEEP and cfg_* changes during SWEEP -> no change to the sweep sequence.
